tb_axi_traffic_gen: RTL and testbench

TB_AXI_TRAFFIC_GEN -- requirements
Module: tb_axi_traffic_gen

---
 rtl/tb_traffic_pkg.sv | 90 +++++++++
 rtl/tb_lfsr32.sv | 24 ++
 rtl/tb_axi_traffic_gen.sv | 158 +++++++++++++++
 tb/tb_tb_axi_traffic_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_traffic_pkg.sv
// Shared definitions for the AXI traffic generator.
//   - tg_state_e : sequencing FSM states
//   - LFSR_TAPS  : Galois feedback taps for the 32-bit address/len LFSR
//   - tg_*_t     : default-width AXI channel/request/response structs
//                  (48-bit addr, 64-bit data, 6-bit id, 1-bit user)
package tb_traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } tg_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int unsigned AXI_ADDR_W = 48;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned AXI_ID_W   = 6;
  localparam int unsigned AXI_USER_W = 1;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [5:0]            atop;
    logic [AXI_USER_W-1:0] user;
  } tg_aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0]   data;
    logic [AXI_DATA_W/8-1:0] strb;
    logic                    last;
    logic [AXI_USER_W-1:0]   user;
  } tg_w_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } tg_b_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } tg_ar_chan_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } tg_r_chan_t;

  typedef struct packed {
    tg_aw_chan_t aw;
    logic        aw_valid;
    tg_w_chan_t  w;
    logic        w_valid;
    logic        b_ready;
    tg_ar_chan_t ar;
    logic        ar_valid;
    logic        r_ready;
  } tg_axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    tg_b_chan_t  b;
    logic        r_valid;
    tg_r_chan_t  r;
  } tg_axi_rsp_t;

endpackage

// File: rtl/tb_lfsr32.sv
// 32-bit Galois LFSR.
//   clk_i/rst_ni : clock, async active-low reset (reset loads seed_i)
//   load_i       : reload with seed_i (priority over en_i)
//   en_i         : advance one step
//   seed_i       : reload / reset value, must be non-zero
//   q_o          : current state
module tb_lfsr32
  import tb_traffic_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic [31:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     q_o <= seed_i;
    else if (load_i) q_o <= seed_i;
    else if (en_i)   q_o <= {1'b0, q_o[31:1]} ^ (q_o[0] ? LFSR_TAPS : 32'h0);
  end

endmodule

// File: rtl/tb_axi_traffic_gen.sv
// AXI write/readback traffic generator. Each transaction is one INCR write
// burst followed by a read of the same addr/len/id; exactly one is in flight.
//   clk_i, rst_ni     : clock, async active-low reset
//   start_i           : one-cycle run request (ignored while busy_o)
//   axi_req_o/rsp_i   : AXI master port
//   busy_o, done_o    : run in progress / run finished (sticky until start)
//   err_o             : sticky, any non-OKAY BRESP/RRESP seen in this run
//   txn_cnt_o         : completed write+readback pairs
module tb_axi_traffic_gen
  import tb_traffic_pkg::*;
#(
  parameter type                  axi_req_t = tg_axi_req_t,
  parameter type                  axi_rsp_t = tg_axi_rsp_t,
  parameter int unsigned          AddrWidth = 48,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          IdWidth   = 6,
  parameter int unsigned          NumTxns   = 64,
  parameter int unsigned          MaxLen    = 7,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0,
  parameter logic [AddrWidth-1:0] AddrSpan  = 'h1_0000,
  parameter logic [31:0]          Seed      = 32'hACE1_0001
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output axi_req_t    axi_req_o,
  input  axi_rsp_t    axi_rsp_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] txn_cnt_o
);

  localparam int unsigned Bytes    = DataWidth / 8;
  localparam int unsigned BlkBytes = (MaxLen + 1) * Bytes;
  localparam int unsigned Reps     = (DataWidth + 31) / 32;
  // Keeps every burst inside its own (MaxLen+1)-beat aligned block.
  localparam logic [AddrWidth-1:0] AddrMask =
    (AddrSpan - 1'b1) & ~AddrWidth'(BlkBytes - 1);

  tg_state_e state_q, state_d;

  logic [31:0]          lfsr_q, lfsr_src, txn_cnt_q, txn_next, w_word;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           len_q, beat_q;
  logic [IdWidth-1:0]   id_q;
  logic                 err_q;
  logic                 go, aw_hs, w_hs, b_hs, ar_hs, r_hs, enter_aw;
  logic [Reps*32-1:0]   w_rep;
  logic                 unused_ok;

  assign go    = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
  assign aw_hs = axi_req_o.aw_valid && axi_rsp_i.aw_ready;
  assign w_hs  = axi_req_o.w_valid  && axi_rsp_i.w_ready;
  assign b_hs  = axi_req_o.b_ready  && axi_rsp_i.b_valid;
  assign ar_hs = axi_req_o.ar_valid && axi_rsp_i.ar_ready;
  assign r_hs  = axi_req_o.r_ready  && axi_rsp_i.r_valid;

  // On start the LFSR reloads this same edge, so the first payload is taken
  // straight from Seed rather than the stale register.
  assign lfsr_src = go ? Seed : lfsr_q;
  assign txn_next = go ? 32'd0 : txn_cnt_q + 32'd1;
  assign enter_aw = (state_d == ST_AW) && (state_q != ST_AW);

  tb_lfsr32 u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (go),
    .en_i   (aw_hs),
    .seed_i (Seed),
    .q_o    (lfsr_q)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_i) state_d = (NumTxns == 0) ? ST_DONE : ST_AW;
      ST_AW: if (aw_hs) state_d = ST_W;
      ST_W:  if (w_hs && axi_req_o.w.last) state_d = ST_B;
      ST_B:  if (b_hs) state_d = ST_AR;
      ST_AR: if (ar_hs) state_d = ST_R;
      ST_R:  if (r_hs && axi_rsp_i.r.last)
               state_d = (txn_cnt_q + 32'd1 < NumTxns) ? ST_AW : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction payload, beat counter and run status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      beat_q    <= '0;
      txn_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (enter_aw) begin
        addr_q <= BaseAddr + (AddrWidth'(lfsr_src) & AddrMask);
        len_q  <= lfsr_src[31:24] & 8'(MaxLen);
        id_q   <= txn_next[IdWidth-1:0];
      end
      if (aw_hs)     beat_q <= '0;
      else if (w_hs) beat_q <= beat_q + 8'd1;
      if (go) begin
        txn_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (r_hs && axi_rsp_i.r.last) txn_cnt_q <= txn_cnt_q + 32'd1;
        if ((b_hs && axi_rsp_i.b.resp != 2'b00) || (r_hs && axi_rsp_i.r.resp != 2'b00))
          err_q <= 1'b1;
      end
    end
  end

  assign w_word = (addr_q[31:0] + 32'(beat_q) * 32'(Bytes)) ^ Seed;
  assign w_rep  = {Reps{w_word}};

  // Outputs: valids/readies are pure state decodes, payload is registered,
  // so both stay stable until the handshake moves the FSM on.
  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = id_q;
    axi_req_o.aw.addr   = addr_q;
    axi_req_o.aw.len    = len_q;
    axi_req_o.aw.size   = 3'($clog2(Bytes));
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw_valid  = (state_q == ST_AW);
    axi_req_o.w.data    = w_rep[DataWidth-1:0];
    axi_req_o.w.strb    = '1;
    axi_req_o.w.last    = (beat_q == len_q);
    axi_req_o.w_valid   = (state_q == ST_W);
    axi_req_o.b_ready   = (state_q == ST_B);
    axi_req_o.ar.id     = id_q;
    axi_req_o.ar.addr   = addr_q;
    axi_req_o.ar.len    = len_q;
    axi_req_o.ar.size   = 3'($clog2(Bytes));
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar_valid  = (state_q == ST_AR);
    axi_req_o.r_ready   = (state_q == ST_R);
    busy_o              = !(state_q == ST_IDLE || state_q == ST_DONE);
    done_o              = (state_q == ST_DONE);
  end

  assign err_o     = err_q;
  assign txn_cnt_o = txn_cnt_q;

  // Response ids, user bits and read data are deliberately not inspected.
  assign unused_ok = ^{axi_rsp_i, txn_next};

endmodule

// File: tb/tb_tb_axi_traffic_gen.sv
// Bench for tb_axi_traffic_gen: three instances (64-txn main run with a
// stalling/erroring slave, 1-txn always-ready, 0-txn), queue scoreboard on
// the main instance fed from its own LFSR model at each start.
module tb_tb_axi_traffic_gen;
  import tb_traffic_pkg::*;

  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam int          NTX  = 64;

  typedef struct {
    logic [47:0] addr;
    logic [7:0]  len;
    logic [5:0]  id;
  } aw_exp_t;
  typedef struct {
    logic [63:0] data;
    logic        last;
  } w_exp_t;

  logic clk, rst_n, start, start1, start0;
  tg_axi_req_t req, req1, req0;
  tg_axi_rsp_t rsp, rsp1, rsp0;
  logic busy, done, err, busy1, done1, err1, busy0, done0, err0;
  logic [31:0] txn, txn1, txn0;

  int n_cmp = 0, n_err = 0;
  int stall_n = 0, err_txn = 1000;
  int aw_cyc = 0, w_beat = 0, b_cnt = 0, r_cnt = 0;
  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  aw_exp_t last_aw;
  tg_aw_chan_t aw_pl;
  logic zero_vld = 1'b0;

  tb_axi_traffic_gen #(.axi_req_t(tg_axi_req_t), .axi_rsp_t(tg_axi_rsp_t),
    .NumTxns(NTX), .MaxLen(7), .Seed(SEED)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .axi_req_o(req), .axi_rsp_i(rsp),
    .busy_o(busy), .done_o(done), .err_o(err), .txn_cnt_o(txn));

  tb_axi_traffic_gen #(.axi_req_t(tg_axi_req_t), .axi_rsp_t(tg_axi_rsp_t),
    .NumTxns(1), .MaxLen(0), .Seed(32'h1)) u_one (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .axi_req_o(req1), .axi_rsp_i(rsp1),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .txn_cnt_o(txn1));

  tb_axi_traffic_gen #(.axi_req_t(tg_axi_req_t), .axi_rsp_t(tg_axi_rsp_t),
    .NumTxns(0)) u_zero (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0), .axi_req_o(req0), .axi_rsp_i(rsp0),
    .busy_o(busy0), .done_o(done0), .err_o(err0), .txn_cnt_o(txn0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main slave: AW stalled stall_n cycles, W/AR always ready, one B per
  // burst, R beats up to the requested len, SLVERR on B number err_txn.
  int aw_wait, sb_idx;
  logic b_pend, r_act;
  logic [7:0] r_beat, r_len;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; sb_idx <= 0; b_pend <= 1'b0; r_act <= 1'b0;
      r_beat <= '0; r_len <= '0;
    end else begin
      if (req.aw_valid) aw_wait <= rsp.aw_ready ? 0 : aw_wait + 1;
      if (req.w_valid && rsp.w_ready && req.w.last) b_pend <= 1'b1;
      if (rsp.b_valid && req.b_ready) b_pend <= 1'b0;
      if (start && !busy) sb_idx <= 0;
      else if (rsp.b_valid && req.b_ready) sb_idx <= sb_idx + 1;
      if (req.ar_valid && rsp.ar_ready) begin
        r_act <= 1'b1; r_len <= req.ar.len; r_beat <= '0;
      end else if (rsp.r_valid && req.r_ready) begin
        r_beat <= r_beat + 8'd1;
        if (rsp.r.last) r_act <= 1'b0;
      end
    end
  end

  always_comb begin
    rsp          = '0;
    rsp.aw_ready = (aw_wait >= stall_n);
    rsp.w_ready  = 1'b1;
    rsp.b_valid  = b_pend;
    rsp.b.resp   = (sb_idx == err_txn) ? 2'b10 : 2'b00;
    rsp.ar_ready = 1'b1;
    rsp.r_valid  = r_act;
    rsp.r.last   = (r_beat == r_len);
  end

  always_comb begin
    rsp1          = '0;
    rsp1.aw_ready = 1'b1;
    rsp1.w_ready  = 1'b1;
    rsp1.ar_ready = 1'b1;
    rsp1.b_valid  = req1.b_ready;
    rsp1.r_valid  = req1.r_ready;
    rsp1.r.last   = 1'b1;
  end

  assign rsp0 = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] s);
    nxt = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Expected traffic for a whole run, queued when start is driven.
  task automatic push_run();
    logic [31:0] s, word;
    logic [47:0] a;
    logic [7:0]  ln;
    aw_q.delete(); w_q.delete();
    b_cnt = 0; r_cnt = 0; aw_cyc = 0; w_beat = 0;
    s = SEED;
    for (int t = 0; t < NTX; t++) begin
      a  = {32'h0, s[15:6], 6'h0};
      ln = {5'h0, s[26:24]};
      aw_q.push_back('{addr: a, len: ln, id: 6'(t)});
      for (int k = 0; k <= int'(ln); k++) begin
        word = (a[31:0] + 32'(k * 8)) ^ SEED;
        w_q.push_back('{data: {word, word}, last: (k == int'(ln))});
      end
      s = nxt(s);
    end
  endtask

  // Sampled at negedge: valid&&ready here is the handshake of the next edge.
  task automatic sample();
    aw_exp_t ea;
    w_exp_t  ew;
    zero_vld = zero_vld | req0.aw_valid | req0.w_valid | req0.ar_valid;
    if (!rst_n) begin
      aw_q.delete(); w_q.delete(); aw_cyc = 0; w_beat = 0;
      return;
    end
    if (start && !busy) push_run();
    if (req.aw_valid) begin
      if (aw_cyc == 0) aw_pl = req.aw;
      else chk("aw_stable", 64'(req.aw === aw_pl), 64'd1);
      chk("w_idle_in_aw", 64'(req.w_valid), 64'd0);
      aw_cyc++;
      if (rsp.aw_ready) begin
        chk("aw_valid_cycles", 64'(aw_cyc), 64'(stall_n + 1));
        if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          ea = aw_q.pop_front();
          chk("aw_addr", 64'(req.aw.addr), 64'(ea.addr));
          chk("aw_len", 64'(req.aw.len), 64'(ea.len));
          chk("aw_id", 64'(req.aw.id), 64'(ea.id));
          chk("aw_size_burst", 64'({req.aw.size, req.aw.burst}), 64'({3'd3, 2'b01}));
          chk("aw_in_block", 64'((req.aw.addr + 48'((req.aw.len + 1) * 8) - 48'd1) >> 6),
              64'(req.aw.addr >> 6));
          last_aw = ea;
        end
        aw_cyc = 0; w_beat = 0;
      end
    end
    if (req.w_valid && rsp.w_ready) begin
      if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
      else begin
        ew = w_q.pop_front();
        chk("w_data", req.w.data, ew.data);
        chk("w_last", 64'(req.w.last), 64'(ew.last));
        chk("w_strb", 64'(req.w.strb), 64'hFF);
      end
      w_beat++;
    end
    if (req.b_ready && rsp.b_valid) begin
      chk("err_before_b", 64'(err), 64'(b_cnt > err_txn));
      b_cnt++;
    end
    if (req.ar_valid && rsp.ar_ready) begin
      chk("ar_addr", 64'(req.ar.addr), 64'(last_aw.addr));
      chk("ar_len_id", 64'({req.ar.len, req.ar.id}), 64'({last_aw.len, last_aw.id}));
    end
    if (req.r_ready && rsp.r_valid && rsp.r.last) begin
      chk("txn_cnt_at_r", 64'(txn), 64'(r_cnt));
      r_cnt++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] oh_exp [5];

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; start0 = 1'b0;
    repeat (2) cyc();
    chk("rst_valids", 64'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 64'd0);
    chk("rst_flags", 64'({busy, done, err}), 64'd0);
    chk("rst_txn_cnt", 64'(txn), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Single-beat transaction through an always-ready slave
    oh_exp = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    start1 = 1'b1; cyc(); start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("one_phase", 64'({req1.aw_valid, req1.w_valid, req1.b_ready, req1.ar_valid, req1.r_ready}),
          64'(oh_exp[i]));
      if (i == 0) chk("one_aw", 64'({req1.aw.addr, req1.aw.len}), 64'd0);
      if (i == 1) chk("one_w_data", req1.w.data, 64'h0000_0001_0000_0001);
      if (i == 1) chk("one_w_last", 64'(req1.w.last), 64'd1);
      cyc();
    end
    chk("one_done_flags", 64'({done1, busy1, err1}), 64'b100);
    chk("one_txn_cnt", 64'(txn1), 64'd1);

    // Zero-transaction run
    chk("zero_not_done", 64'(done0), 64'd0);
    start0 = 1'b1; cyc(); start0 = 1'b0;
    chk("zero_done_next", 64'({done0, busy0}), 64'b10);

    // Main run: AW held off 5 cycles each time, SLVERR on the 4th B
    stall_n = 5; err_txn = 3;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    start = 1'b1; cyc(); start = 1'b0;
    chk("busy_start_ignored", 64'(busy), 64'd1);
    for (int i = 0; i < 20000 && !done; i++) cyc();
    chk("run1_done", 64'(done), 64'd1);
    chk("run1_txn_cnt", 64'(txn), 64'd64);
    chk("run1_err", 64'(err), 64'd1);
    chk("run1_queues_drained", 64'(aw_q.size() + w_q.size()), 64'd0);

    // Reset in the middle of the first write burst, then restart
    stall_n = 0; err_txn = 1000;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 100 && !(req.w_valid && w_beat == 2); i++) cyc();
    chk("reached_w_beat2", 64'({req.w_valid, 8'(w_beat)}), 64'({1'b1, 8'd2}));
    rst_n = 1'b0;
    #1;
    chk("midburst_rst_valids",
        64'({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}), 64'd0);
    chk("midburst_rst_flags", 64'({busy, done, err}), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("no_auto_restart", 64'({busy, req.aw_valid}), 64'd0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_first_addr", 64'(req.aw.addr), 64'({SEED[15:6], 6'h0}));
    chk("restart_first_len", 64'(req.aw.len), 64'(SEED[26:24]));
    for (int i = 0; i < 20000 && !done; i++) cyc();
    chk("run2_done", 64'(done), 64'd1);
    chk("run2_txn_cnt", 64'(txn), 64'd64);
    chk("run2_err", 64'(err), 64'd0);
    chk("zero_never_valid", 64'(zero_vld), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
